// File: rtl/cache_pkg.sv
// Shared types and helpers for the N-way L1 cache: controller state encoding,
// default geometry and a constant-foldable log2 used for field widths.
package cache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOOKUP = 3'd1,
      ST_FILL   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_RESP   = 3'd4
   } state_e;

   localparam int DEF_ADDR_W = 7;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_WAYS   = 2;
   localparam int DEF_SETS   = 2;
   localparam int DEF_WORDS  = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/cache_lru_set.sv
// True-LRU age vector for one set. Age 0 is most recent, WAYS-1 is the victim;
// the ages stay a permutation of 0..WAYS-1 at all times.
module cache_lru_set
   import cache_pkg::*;
#(
   parameter int WAYS  = DEF_WAYS,
   parameter int WAY_W = clog2(WAYS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             touch_i,
   input  logic [WAY_W-1:0] touch_way_i,
   output logic [WAY_W-1:0] victim_way_o
);

   logic [WAY_W-1:0] age_q [WAYS];
   logic [WAY_W-1:0] age_d [WAYS];

   always_comb begin
      age_d = age_q;
      if (touch_i) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age_q[w] < age_q[touch_way_i]) age_d[w] = age_q[w] + WAY_W'(1);
         end
         age_d[touch_way_i] = '0;
      end
   end

   always_comb begin
      victim_way_o = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (age_q[w] == WAY_W'(WAYS - 1)) victim_way_o = WAY_W'(w);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int w = 0; w < WAYS; w++) age_q[w] <= WAY_W'(w);
      end else begin
         age_q <= age_d;
      end
   end

endmodule

// File: rtl/cache_l1_nway.sv
// N-way set-associative, write-through, no-write-allocate L1 with true-LRU.
// Handshake: a transfer happens on a rising edge where valid && ready; valid side holds its payload until then.
module cache_l1_nway
   import cache_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int WAYS   = DEF_WAYS,
   parameter int SETS   = DEF_SETS,
   parameter int WORDS  = DEF_WORDS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wren,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_rdata,
   output state_e            dbg_state_o
);

   localparam int OFF_W = clog2(WORDS);
   localparam int IDX_W = clog2(SETS);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
   localparam int WAY_W = clog2(WAYS);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wren_q, wren_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              hit_q, hit_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [WAY_W-1:0]  way_q, way_d;
   logic [OFF_W-1:0]  fill_cnt_q, fill_cnt_d;
   logic              rd_out_q, rd_out_d;

   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [WAYS-1:0]   valid_q [SETS];
   logic [DATA_W-1:0] data_q  [SETS][WAYS][WORDS];

   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic [OFF_W-1:0]  req_off;
   logic              hit;
   logic [WAY_W-1:0]  hit_way;
   logic              inv_found;
   logic [WAY_W-1:0]  inv_way;
   logic [WAY_W-1:0]  victim;
   logic [WAY_W-1:0]  lru_victim [SETS];
   logic              touch;
   logic [WAY_W-1:0]  touch_way;
   logic              wr_hit_en;
   logic              fill_wr_en;
   logic              fill_done;
   logic              mem_fire;
   logic              rd_live;

   assign req_tag = addr_q[ADDR_W-1 -: TAG_W];
   assign req_idx = addr_q[OFF_W +: IDX_W];
   assign req_off = addr_q[OFF_W-1:0];

   // Parallel tag compare; the invalid-way scan runs high-to-low so the lowest index wins.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[req_idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      victim = inv_found ? inv_way : lru_victim[req_idx];
   end

   for (genvar s = 0; s < SETS; s++) begin : g_lru
      cache_lru_set #(.WAYS(WAYS)) u_lru (
         .clk          (clk),
         .reset        (reset),
         .touch_i      (touch && (req_idx == IDX_W'(s))),
         .touch_way_i  (touch_way),
         .victim_way_o (lru_victim[s])
      );
   end

   assign req_ready     = (state_q == ST_IDLE);
   assign resp_valid    = (state_q == ST_RESP);
   assign resp_hit      = resp_valid && hit_q;
   assign resp_rdata    = rdata_q;
   assign mem_req_valid = ((state_q == ST_FILL) && !rd_out_q) || (state_q == ST_WRITE);
   assign mem_req_we    = (state_q == ST_WRITE);
   assign mem_req_addr  = (state_q == ST_FILL)  ? {req_tag, req_idx, fill_cnt_q} :
                          (state_q == ST_WRITE) ? addr_q : '0;
   assign mem_req_wdata = (state_q == ST_WRITE) ? wdata_q : '0;
   assign mem_fire      = mem_req_valid && mem_req_ready;
   assign dbg_state_o   = state_q;
   // A fill word counts if a read is outstanding or retires in this same cycle.
   assign rd_live       = rd_out_q || mem_fire;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wren_d     = wren_q;
      wdata_d    = wdata_q;
      hit_d      = hit_q;
      rdata_d    = rdata_q;
      way_d      = way_q;
      fill_cnt_d = fill_cnt_q;
      rd_out_d   = rd_out_q;
      touch      = 1'b0;
      touch_way  = way_q;
      wr_hit_en  = 1'b0;
      fill_wr_en = 1'b0;
      fill_done  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d    = ST_LOOKUP;
               addr_d     = req_addr;
               wren_d     = req_wren;
               wdata_d    = req_wdata;
               hit_d      = 1'b0;
               rdata_d    = '0;
               fill_cnt_d = '0;
               rd_out_d   = 1'b0;
            end
         end
         ST_LOOKUP: begin
            hit_d = hit;
            way_d = hit ? hit_way : victim;
            if (wren_q) begin
               wr_hit_en = hit;
               touch     = hit;
               touch_way = hit_way;
               state_d   = ST_WRITE;
            end else if (hit) begin
               rdata_d   = data_q[req_idx][hit_way][req_off];
               touch     = 1'b1;
               touch_way = hit_way;
               state_d   = ST_RESP;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            rd_out_d = rd_live && !mem_resp_valid;
            if (mem_resp_valid && rd_live) begin
               fill_wr_en = 1'b1;
               fill_cnt_d = fill_cnt_q + OFF_W'(1);
               if (fill_cnt_q == req_off) rdata_d = mem_resp_rdata;
               if (fill_cnt_q == OFF_W'(WORDS - 1)) begin
                  fill_done = 1'b1;
                  touch     = 1'b1;
                  touch_way = way_q;
                  state_d   = ST_RESP;
               end
            end
         end
         ST_WRITE: begin
            if (mem_req_ready) state_d = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         wren_q     <= 1'b0;
         wdata_q    <= '0;
         hit_q      <= 1'b0;
         rdata_q    <= '0;
         way_q      <= '0;
         fill_cnt_q <= '0;
         rd_out_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wren_q     <= wren_d;
         wdata_q    <= wdata_d;
         hit_q      <= hit_d;
         rdata_q    <= rdata_d;
         way_q      <= way_d;
         fill_cnt_q <= fill_cnt_d;
         rd_out_q   <= rd_out_d;
      end
   end

   // Tags and data are never reset; only the valid bits gate their use.
   always_ff @(posedge clk) begin
      if (wr_hit_en)  data_q[req_idx][hit_way][req_off]  <= wdata_q;
      if (fill_wr_en) data_q[req_idx][way_q][fill_cnt_q] <= mem_resp_rdata;
      if (fill_done)  tag_q[req_idx][way_q]              <= req_tag;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end else if (fill_done) begin
         valid_q[req_idx][way_q] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cache_l1_nway.sv
// Randomized bench for cache_l1_nway: a next-level memory responder, and a
// reference model built from per-set MRU-ordered tag lists plus a flat memory image.
module tb_cache_l1_nway;
   import cache_pkg::*;

   localparam int WAYS = 2;
   localparam int SETS = 2;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_wren;
   logic [6:0]  req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic        resp_hit;
   logic [15:0] resp_rdata;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_we;
   logic [6:0]  mem_req_addr;
   logic [15:0] mem_req_wdata;
   logic        mem_resp_valid;
   logic [15:0] mem_resp_rdata;
   state_e      dbg_state;

   cache_l1_nway dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_wren       (req_wren),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_hit       (resp_hit),
      .resp_rdata     (resp_rdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_we     (mem_req_we),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata),
      .dbg_state_o    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          n_total = 0;
   int          n_bad   = 0;
   logic [23:0] exp_q[$];
   logic [23:0] obs_q[$];
   int          set_q[SETS][$];
   logic [15:0] ref_mem [128];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- next-level memory responder ----------------
   logic [15:0] mem_store [128];
   int          wait_cnt  = 0;
   int          pend      = 0;
   int          pend_dly  = 0;
   logic [6:0]  pend_addr = '0;
   logic [23:0] cap       = '0;
   int          stray_req = 0;

   initial begin
      for (int a = 0; a < 128; a++) mem_store[a] = 16'h1000 + 16'(a);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
   end

   always @(negedge clk) begin
      mem_resp_valid = 1'b0;
      if (reset) begin
         mem_req_ready = 1'b0;
         wait_cnt      = 0;
         pend          = 0;
         obs_q.delete();
      end else begin
         if (stray_req != 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = 16'hDEAD;
            stray_req      = 0;
         end else if (pend != 0) begin
            if (pend_dly == 0) begin
               mem_resp_valid = 1'b1;
               mem_resp_rdata = mem_store[pend_addr];
               pend           = 0;
            end else begin
               pend_dly--;
            end
         end
         if (mem_req_ready) begin
            obs_q.push_back(cap);
            if (cap[23]) begin
               mem_store[cap[22:16]] = cap[15:0];
            end else begin
               pend      = 1;
               pend_addr = cap[22:16];
               pend_dly  = $urandom_range(0, 2);
            end
            mem_req_ready = 1'b0;
            wait_cnt      = 0;
         end else if (mem_req_valid) begin
            wait_cnt++;
            if (wait_cnt >= 2) begin
               mem_req_ready = 1'b1;
               cap = {mem_req_we, mem_req_addr, mem_req_we ? mem_req_wdata : 16'h0};
            end
         end
      end
   end

   // ---------------- driver + reference model ----------------
   task automatic do_req(input logic wren, input logic [6:0] addr, input logic [15:0] wdata,
                         input string nm);
      int          s;
      int          t;
      int          pos;
      int          n;
      int          lat;
      logic        exp_hit;
      logic [15:0] exp_rd;
      logic [6:0]  base;
      logic [23:0] e;
      logic [23:0] o;
      s    = int'(addr[1]);
      t    = int'(addr[6:2]);
      base = {addr[6:1], 1'b0};
      pos  = -1;
      for (int i = 0; i < set_q[s].size(); i++) if (set_q[s][i] == t) pos = i;
      exp_hit = (pos >= 0);
      if (wren) begin
         exp_rd = 16'h0;
         exp_q.push_back({1'b1, addr, wdata});
         ref_mem[addr] = wdata;
         if (exp_hit) begin
            set_q[s].delete(pos);
            set_q[s].push_front(t);
         end
      end else begin
         exp_rd = ref_mem[addr];
         if (exp_hit) begin
            set_q[s].delete(pos);
         end else begin
            for (int k = 0; k < 2; k++) exp_q.push_back({1'b0, 7'(base + 7'(k)), 16'h0});
            if (set_q[s].size() == WAYS) void'(set_q[s].pop_back());
         end
         set_q[s].push_front(t);
      end

      @(negedge clk);
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk({nm, "_ready_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_wren  = wren;
      req_addr  = addr;
      req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, "_resp"}, 32'(resp_valid), 32'd1);
      chk({nm, "_hit"}, 32'(resp_hit), 32'(exp_hit));
      chk({nm, "_rdata"}, 32'(resp_rdata), 32'(exp_rd));
      if (!wren && exp_hit) chk({nm, "_hit_latency"}, 32'(lat), 32'd2);
      @(negedge clk);
      chk({nm, "_resp_pulse"}, 32'(resp_valid), 32'd0);
      chk({nm, "_mem_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         chk({nm, "_mem_txn"}, 32'(o), 32'(e));
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      logic [6:0] a;
      for (int i = 0; i < 128; i++) ref_mem[i] = 16'h1000 + 16'(i);
      reset     = 1'b1;
      req_valid = 1'b0;
      req_wren  = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      reset = 1'b0;

      do_req(1'b0, 7'h04, 16'h0, "rd04_miss");
      do_req(1'b0, 7'h05, 16'h0, "rd05_hit");
      do_req(1'b0, 7'h00, 16'h0, "rd00_miss");
      do_req(1'b0, 7'h08, 16'h0, "rd08_evict");
      do_req(1'b0, 7'h00, 16'h0, "rd00_hit");
      do_req(1'b0, 7'h04, 16'h0, "rd04_remiss");
      do_req(1'b1, 7'h05, 16'hABCD, "wr05_hit");
      do_req(1'b0, 7'h05, 16'h0, "rd05_after_wr");
      do_req(1'b1, 7'h40, 16'h1234, "wr40_miss");
      do_req(1'b0, 7'h40, 16'h0, "rd40_noalloc");

      // Reset in the middle of a fill, after the first word is stored.
      @(negedge clk);
      req_valid = 1'b1;
      req_wren  = 1'b0;
      req_addr  = 7'h10;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!mem_resp_valid && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("midfill_word0_seen", 32'(mem_resp_valid), 32'd1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midfill_rst_req_ready", 32'(req_ready), 32'd1);
      chk("midfill_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midfill_rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("midfill_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      for (int s = 0; s < SETS; s++) set_q[s].delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset     = 1'b0;
      stray_req = 1;
      repeat (3) begin
         @(negedge clk);
         chk("stray_resp_valid", 32'(resp_valid), 32'd0);
         chk("stray_mem_req_valid", 32'(mem_req_valid), 32'd0);
      end
      chk("stray_state", 32'(dbg_state), 32'(ST_IDLE));
      do_req(1'b0, 7'h10, 16'h0, "rd10_after_rst");

      // Random traffic, mostly on a small footprint so hits and evictions mix.
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 4) == 0) a = 7'($urandom_range(0, 127));
         else a = 7'($urandom_range(0, 15));
         if ($urandom_range(0, 9) < 3) do_req(1'b1, a, 16'($urandom), "rnd_wr");
         else do_req(1'b0, a, 16'h0, "rnd_rd");
      end

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      n_total++;
      n_bad++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
